// File: rtl/clk_gate_ctrl_pkg.sv
// clk_gate_ctrl_pkg
//  Shared types and helpers for the clock-gate sequencer.
//  Contents:
//    cg_state_t - per-domain sequencing state (OFF, WAKE, ON, IDLE)
//    cg_cnt_w   - width of the per-domain wake/idle down-counter
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_ON, CG_IDLE} cg_state_t;

  // The single per-domain counter serves both the wake delay and the idle
  // timeout, so it is sized for the larger of the two reload values.
  // The result is never below 1, so that a zero-width vector is avoided.
  function automatic int cg_cnt_w(input int idle, input int wake);
    int mx;
    mx = (idle > wake) ? idle : wake;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_dom.sv
// clk_gate_ctrl_dom
//  Sequencer for a single gated clock domain. It holds the domain FSM and
//  one down-counter that is shared by the wake delay and the idle timeout.
//  Ports:
//    CLK     in  free-running always-on clock
//    RST     in  synchronous, active-high reset
//    grant   in  wake permission from the top-level arbiter (asserted only while OFF)
//    req     in  effective activity request for this domain
//    state   out current FSM state
//    gate_en out ICG enable, registered
//    ack     out gated clock running and stable, registered
module clk_gate_ctrl_dom
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      grant,
  input  logic      req,
  output cg_state_t state,
  output logic      gate_en,
  output logic      ack
);

  localparam int CNT_W = cg_cnt_w(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam bit IDLE_BYPASS = (IDLE_CYCLES == 0);

  logic [CNT_W-1:0] cnt;

  // Domain FSM. gate_en and ack are registered together with the state, so
  // both change only just after a CLK rising edge. This keeps the ICG E pin
  // stable while the negative-edge ICG latch is transparent.
  // A WAKE always runs to completion; a request that drops during WAKE is
  // handled from ON. While in ON the idle counter is kept reloaded, so that
  // every ON->IDLE entry starts a full timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CG_OFF;
      cnt     <= '0;
      gate_en <= 1'b0;
      ack     <= 1'b0;
    end else begin
      case (state)
        CG_OFF: begin
          if (grant) begin
            state   <= CG_WAKE;
            cnt     <= WAKE_LOAD;
            gate_en <= 1'b1;
            ack     <= 1'b0;
          end
        end
        CG_WAKE: begin
          if (cnt == '0) begin
            state <= CG_ON;
            cnt   <= IDLE_LOAD;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CG_ON: begin
          if (!req) begin
            if (IDLE_BYPASS) begin
              state   <= CG_OFF;
              cnt     <= '0;
              gate_en <= 1'b0;
              ack     <= 1'b0;
            end else begin
              state <= CG_IDLE;
              cnt   <= IDLE_LOAD;
            end
          end else begin
            cnt <= IDLE_LOAD;
          end
        end
        CG_IDLE: begin
          if (req) begin
            state <= CG_ON;
            cnt   <= IDLE_LOAD;
          end else if (cnt == '0) begin
            state   <= CG_OFF;
            gate_en <= 1'b0;
            ack     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= CG_OFF;
          cnt     <= '0;
          gate_en <= 1'b0;
          ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//  Sequencer for N_DOM gated clock domains. Each domain is clocked through a
//  negative-edge ICG cell. Wake-ups are serialised, one domain at a time,
//  and chosen round-robin, which bounds inrush current. A domain is gated
//  off only after it has been idle for a timeout.
//  Optional feature macro: CGC_FORCE_ON_EN. When it is defined, the block
//  has a FORCE_ON input. While FORCE_ON is high, every domain is held
//  requesting.
//  Ports:
//    CLK      in  free-running always-on clock
//    RST      in  synchronous, active-high reset
//    FORCE_ON in  (only with CGC_FORCE_ON_EN) treat every domain as requesting
//    REQ      in  [N_DOM] per-domain activity request, level
//    GATE_EN  out [N_DOM] per-domain ICG enable, registered
//    ACK      out [N_DOM] per-domain clock running and stable, registered
//    BUSY     out a domain is in WAKE
//    ALL_OFF  out every domain is in OFF
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef CGC_FORCE_ON_EN
  input  logic             FORCE_ON,
`endif
  input  logic [N_DOM-1:0] REQ,
  output logic [N_DOM-1:0] GATE_EN,
  output logic [N_DOM-1:0] ACK,
  output logic             BUSY,
  output logic             ALL_OFF
);

  localparam int PW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic [N_DOM-1:0] reqEff;
  logic [N_DOM-1:0] offMask;
  logic [N_DOM-1:0] wakeMask;
  logic [N_DOM-1:0] grantVec;
  logic [PW-1:0]    rrPtr;
  logic [PW-1:0]    grantIdx;
  logic             grantValid;
  cg_state_t        domState [N_DOM];

  // Wraps pointer+offset back into 0..N_DOM-1. The offset is always below
  // N_DOM, so a single subtraction is enough.
  function automatic int wrapIdx(input int v);
    return (v >= N_DOM) ? v - N_DOM : v;
  endfunction

`ifdef CGC_FORCE_ON_EN
  assign reqEff = REQ | {N_DOM{FORCE_ON}};
`else
  assign reqEff = REQ;
`endif

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    clk_gate_ctrl_dom #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
    ) u_dom (
      .CLK    (CLK),
      .RST    (RST),
      .grant  (grantVec[i]),
      .req    (reqEff[i]),
      .state  (domState[i]),
      .gate_en(GATE_EN[i]),
      .ack    (ACK[i])
    );
    assign offMask[i]  = (domState[i] == CG_OFF);
    assign wakeMask[i] = (domState[i] == CG_WAKE);
  end

  assign BUSY    = |wakeMask;
  assign ALL_OFF = &offMask;

  // Round-robin arbiter. Candidates are scanned in order of their distance
  // from rrPtr, and the first requesting OFF domain wins. Nothing is granted
  // while a domain is still in WAKE; this is what serialises the wake-ups.
  always_comb begin
    grantVec   = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    for (int k = 0; k < N_DOM; k++) begin
      for (int j = 0; j < N_DOM; j++) begin
        if (!grantValid && !BUSY && offMask[j] && reqEff[j] &&
            (j == wrapIdx(int'(rrPtr) + k))) begin
          grantValid  = 1'b1;
          grantVec[j] = 1'b1;
          grantIdx    = PW'(j);
        end
      end
    end
  end

  // The pointer moves to the domain after the one just granted. This gives
  // every other requester priority before the winner gets another turn.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rrPtr <= '0;
    end else if (grantValid) begin
      rrPtr <= (int'(grantIdx) == N_DOM - 1) ? '0 : grantIdx + PW'(1);
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl
//  Directed bench for clk_gate_ctrl (N_DOM=4, IDLE_CYCLES=8, WAKE_CYCLES=2).
//  Vector tables are replayed one clock each. Hand-written sequences cover
//  the idle re-raise, a reset during a wake, and the pointer reset. A
//  FORCE_ON sequence is added when CGC_FORCE_ON_EN is defined.
module tb_clk_gate_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'h0;
  logic [3:0] GATE_EN;
  logic [3:0] ACK;
  logic       BUSY;
  logic       ALL_OFF;
`ifdef CGC_FORCE_ON_EN
  logic       FORCE_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic       rst;
    logic [3:0] gate;
    logic [3:0] ack;
    logic       busy;
    logic       allOff;
  } vec_t;

  vec_t vecs[$];

  clk_gate_ctrl #(
    .N_DOM(4),
    .IDLE_CYCLES(8),
    .WAKE_CYCLES(2)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
`ifdef CGC_FORCE_ON_EN
    .FORCE_ON(FORCE_ON),
`endif
    .REQ    (REQ),
    .GATE_EN(GATE_EN),
    .ACK    (ACK),
    .BUSY   (BUSY),
    .ALL_OFF(ALL_OFF)
  );

  always #5 CLK = ~CLK;

  // Drives the inputs, then waits for the next rising edge plus 1 time unit.
  // Outputs are therefore sampled away from the clock edge.
  task automatic applyStimulus(input logic [3:0] req, input logic rst);
    REQ = req;
    RST = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGate,
                             input logic [3:0] expAck, input logic expBusy,
                             input logic expAllOff);
    total++;
    if (GATE_EN !== expGate) begin
      bad++;
      $display("[TB] FAIL %s gate_en: got %b want %b", tag, GATE_EN, expGate);
    end
    total++;
    if (ACK !== expAck) begin
      bad++;
      $display("[TB] FAIL %s ack: got %b want %b", tag, ACK, expAck);
    end
    total++;
    if (BUSY !== expBusy) begin
      bad++;
      $display("[TB] FAIL %s busy: got %b want %b", tag, BUSY, expBusy);
    end
    total++;
    if (ALL_OFF !== expAllOff) begin
      bad++;
      $display("[TB] FAIL %s all_off: got %b want %b", tag, ALL_OFF, expAllOff);
    end
  endtask

  function automatic void addRow(input logic [3:0] req, input logic rst,
                                 input logic [3:0] gate, input logic [3:0] ack,
                                 input logic busy, input logic allOff);
    vecs.push_back('{req, rst, gate, ack, busy, allOff});
  endfunction

  // Builds the wake ramp that starts from all-OFF with every domain
  // requesting. Domains 0..3 are granted in turn, each followed by two WAKE
  // cycles; the next grant comes one cycle after the previous ACK.
  function automatic void addRamp(input logic [3:0] req, input int rows);
    logic [3:0] g;
    logic [3:0] a;
    int n;
    n = 0;
    for (int d = 0; d < 4; d++) begin
      g = 4'((1 << (d + 1)) - 1);
      a = 4'((1 << d) - 1);
      if (n < rows) addRow(req, 1'b0, g, a, 1'b1, 1'b0);
      n++;
      if (n < rows) addRow(req, 1'b0, g, a, 1'b1, 1'b0);
      n++;
      if (n < rows) addRow(req, 1'b0, g, g, 1'b0, 1'b0);
      n++;
    end
  endfunction

  task automatic runTable(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].rst);
      checkOutput($sformatf("%s[%0d]", tag, i), vecs[i].gate, vecs[i].ack,
                  vecs[i].busy, vecs[i].allOff);
    end
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset is held with every request active, so nothing may wake.
    for (int i = 0; i < 3; i++) addRow(4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    // Release: domain 0 must be granted first, then 1, 2, 3.
    addRamp(4'hF, 12);
    // Domain 1 drops its request. It falls 8 edges after the first low sample.
    for (int i = 0; i < 8; i++) addRow(4'hD, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) addRow(4'hD, 1'b0, 4'hD, 4'hD, 1'b0, 1'b0);
    runTable("ramp");

    // Domain 1 wakes again. It is the only OFF requester.
    applyStimulus(4'hF, 1'b0); checkOutput("rewake1", 4'hF, 4'hD, 1'b1, 1'b0);
    applyStimulus(4'hF, 1'b0); checkOutput("rewake2", 4'hF, 4'hD, 1'b1, 1'b0);
    applyStimulus(4'hF, 1'b0); checkOutput("rewake3", 4'hF, 4'hF, 1'b0, 1'b0);

    // Idle for 5 cycles, then the request comes back. Domain 1 returns to
    // ON with no wake. It must never gate off, even well past the timeout.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'hD, 1'b0);
      checkOutput($sformatf("idle%0d", i), 4'hF, 4'hF, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'hF, 1'b0);
      checkOutput($sformatf("reraise%0d", i), 4'hF, 4'hF, 1'b0, 1'b0);
    end

    // Reset while domain 3 is in WAKE and domain 0 is ON.
    applyStimulus(4'hF, 1'b1); checkOutput("rst_a", 4'h0, 4'h0, 1'b0, 1'b1);
    addRamp(4'hF, 10);
    runTable("ramp2");
    applyStimulus(4'hF, 1'b1); checkOutput("rst_midwake", 4'h0, 4'h0, 1'b0, 1'b1);

    // Single-domain wake of domain 2, followed by its idle timeout.
    applyStimulus(4'h4, 1'b0); checkOutput("d2_t1", 4'h4, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h4, 1'b0); checkOutput("d2_t2", 4'h4, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h4, 1'b0); checkOutput("d2_t3", 4'h4, 4'h4, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, 1'b0);
      checkOutput($sformatf("d2_idle%0d", i), 4'h4, 4'h4, 1'b0, 1'b0);
    end
    applyStimulus(4'h0, 1'b0); checkOutput("d2_off", 4'h0, 4'h0, 1'b0, 1'b1);

    // The pointer is 3 at this point. Reset must clear it, so that
    // REQ=1010 wakes domain 1 before domain 3.
    applyStimulus(4'h0, 1'b1); checkOutput("rst_ptr", 4'h0, 4'h0, 1'b0, 1'b1);
    applyStimulus(4'hA, 1'b0); checkOutput("ptr_t1", 4'h2, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b0); checkOutput("ptr_t2", 4'h2, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b0); checkOutput("ptr_t3", 4'h2, 4'h2, 1'b0, 1'b0);
    applyStimulus(4'hA, 1'b0); checkOutput("ptr_t4", 4'hA, 4'h2, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b0); checkOutput("ptr_t5", 4'hA, 4'h2, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b0); checkOutput("ptr_t6", 4'hA, 4'hA, 1'b0, 1'b0);

`ifdef CGC_FORCE_ON_EN
    // FORCE_ON with no requests: all domains wake in RR order and stay on.
    // After release, all of them gate off together once the timeout expires.
    applyStimulus(4'h0, 1'b1); checkOutput("frc_rst", 4'h0, 4'h0, 1'b0, 1'b1);
    FORCE_ON = 1'b1;
    addRamp(4'h0, 12);
    for (int i = 0; i < 12; i++) addRow(4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    runTable("force");
    FORCE_ON = 1'b0;
    for (int i = 0; i < 8; i++) addRow(4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    addRow(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    runTable("unforce");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
